// File: rtl/stoch_acc_pkg.sv
// Shared types and sizing helpers for the stochastic-product accumulate/capture stage.
package stoch_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } acc_state_t;

  // Bits needed to hold a popcount of 0..lanes.
  function automatic int pc_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/popcount_lanes.sv
// Combinational popcount of the product lanes: nibble counts reduced by a binary adder tree.
module popcount_lanes
  import stoch_acc_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic [LANES-1:0]              bits_i,
  output logic [pc_width(LANES)-1:0]    count_o
);

  localparam int PW = pc_width(LANES);
  localparam int NG = LANES / 4;

  // Heap layout: leaves at [NG-1 .. 2*NG-2], root at [0].
  logic [PW-1:0] node [2*NG-1];

  always_comb begin
    for (int i = 0; i < 2*NG-1; i++) begin
      node[i] = '0;
    end
    for (int g = 0; g < NG; g++) begin
      node[NG-1+g] = PW'(bits_i[4*g])   + PW'(bits_i[4*g+1]) +
                     PW'(bits_i[4*g+2]) + PW'(bits_i[4*g+3]);
    end
    for (int n = NG-2; n >= 0; n--) begin
      node[n] = node[2*n+1] + node[2*n+2];
    end
  end

  assign count_o = node[0];

endmodule

// File: rtl/stoch_acc_capture.sv
// Accumulates stochastic product lanes through a popcount/accumulate pipeline and
// presents the saturated per-stream count with a valid/ready result handshake.
module stoch_acc_capture
  import stoch_acc_pkg::*;
#(
  parameter int LANES = 16,
  parameter int WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANES-1:0]  data_in,
  input  logic              in_valid,
  input  logic              done_in,
  output logic              in_ready,
  output logic [WIDTH-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overflow,
  output logic              busy,
  output acc_state_t        state_dbg
);

  localparam int PW = pc_width(LANES);

  // Handshakes: a beat transfers on a rising edge where in_valid && in_ready; a result
  // transfers on a rising edge where result_valid && result_ready. Ready/valid outputs
  // are decoded from registered state only, never from the partner's signal.

  acc_state_t        state_q, state_d;
  logic              drain_cnt_q, drain_cnt_d;
  logic [PW-1:0]     pc_reg_q, pc_reg_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [WIDTH-1:0]  result_q;
  logic              overflow_q;
  logic              accept;
  logic              capture;
  logic [PW-1:0]     pc_now;
  logic [WIDTH:0]    sum;

  popcount_lanes #(.LANES(LANES)) u_popcount (
    .bits_i  (data_in),
    .count_o (pc_now)
  );

  assign in_ready     = (state_q == IDLE) || (state_q == ACCUM);
  assign result_valid = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign accept       = in_valid && in_ready;
  assign result       = result_q;
  assign overflow     = overflow_q;
  assign state_dbg    = state_q;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = done_in ? DRAIN : ACCUM;
      end
      ACCUM: begin
        if (accept && done_in) state_d = DRAIN;
      end
      DRAIN: begin
        // Two cycles let the last popcount reach acc before it is captured.
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) begin
          state_d     = HOLD;
          drain_cnt_d = 1'b0;
          capture     = 1'b1;
        end
      end
      HOLD: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_reg_d  = accept ? pc_now : '0;
    sum       = {1'b0, acc_q} + (WIDTH+1)'(pc_reg_q);
    acc_d     = sum[WIDTH-1:0];
    ovf_acc_d = ovf_acc_q;
    if (capture) begin
      acc_d     = '0;
      ovf_acc_d = 1'b0;
    end else if (sum[WIDTH]) begin
      acc_d     = '1;
      ovf_acc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= 1'b0;
      pc_reg_q    <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      pc_reg_q    <= pc_reg_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      if (capture) begin
        result_q   <= acc_q;
        overflow_q <= ovf_acc_q;
      end
    end
  end

endmodule

// File: tb/tb_stoch_acc_capture.sv
// Self-checking bench for stoch_acc_capture: table vectors, hand-written corner sequences
// and randomized streams, with WIDTH=10 and WIDTH=5 instances driven in lockstep.
module tb_stoch_acc_capture;
  import stoch_acc_pkg::*;

  localparam int LANES = 16;
  localparam int W     = 10;
  localparam int WS    = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [LANES-1:0]  data_in;
  logic              in_valid;
  logic              done_in;
  logic              result_ready;
  logic              in_ready, in_ready_s;
  logic [W-1:0]      result;
  logic [WS-1:0]     result_s;
  logic              result_valid, result_valid_s;
  logic              overflow, overflow_s;
  logic              busy, busy_s;
  acc_state_t        state_dbg, state_dbg_s;

  stoch_acc_capture #(.LANES(LANES), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .done_in(done_in),
    .in_ready(in_ready), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .overflow(overflow), .busy(busy), .state_dbg(state_dbg)
  );

  stoch_acc_capture #(.LANES(LANES), .WIDTH(WS)) dut_s (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .done_in(done_in),
    .in_ready(in_ready_s), .result(result_s), .result_valid(result_valid_s),
    .result_ready(result_ready), .overflow(overflow_s), .busy(busy_s), .state_dbg(state_dbg_s)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];   // per-stream raw ones count, oldest first
  bit m_accepting, m_in_stream, m_hold;
  int m_cnt, m_total;

  typedef struct {
    logic [15:0] beats [4];
    int          n;
    int          exp10;
    int          exp5;
    int          ovf5;
  } vec_t;

  vec_t tbl [6];

  function automatic int sat(input int total, input int w);
    return (total > (1 << w) - 1) ? (1 << w) - 1 : total;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_accepting = 1'b1;
    m_in_stream = 1'b0;
    m_hold      = 1'b0;
    m_cnt       = 0;
    m_total     = 0;
    exp_q.delete();
  endtask

  // One clock: advance the model from pre-edge inputs, then check outputs after the edge.
  task automatic cycle();
    bit acc_now, hs;
    acc_now = in_valid && m_accepting;
    hs      = m_hold && result_ready;
    @(posedge clk);
    if (hs) begin
      m_hold      = 1'b0;
      m_accepting = 1'b1;
      void'(exp_q.pop_front());
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_hold = 1'b1;
    end
    if (acc_now) begin
      m_total += $countones(data_in);
      if (done_in) begin
        exp_q.push_back(W'(m_total));
        m_total     = 0;
        m_accepting = 1'b0;
        m_in_stream = 1'b0;
        m_cnt       = 2;
      end else begin
        m_in_stream = 1'b1;
      end
    end
    #1;
    chk("in_ready", int'(in_ready), int'(m_accepting));
    chk("in_ready_s", int'(in_ready_s), int'(m_accepting));
    chk("result_valid", int'(result_valid), int'(m_hold));
    chk("result_valid_s", int'(result_valid_s), int'(m_hold));
    chk("busy", int'(busy), int'(m_in_stream || !m_accepting));
    if (m_hold && exp_q.size() > 0) begin
      chk("result", int'(result), sat(int'(exp_q[0]), W));
      chk("overflow", int'(overflow), int'(int'(exp_q[0]) > (1 << W) - 1));
      chk("result_s", int'(result_s), sat(int'(exp_q[0]), WS));
      chk("overflow_s", int'(overflow_s), int'(int'(exp_q[0]) > (1 << WS) - 1));
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    done_in  = 1'b0;
    data_in  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_result", int'(result), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_state", int'(state_dbg), int'(IDLE));
    chk("rst_result_s", int'(result_s), 0);
    chk("rst_overflow_s", int'(overflow_s), 0);
    chk("rst_state_s", int'(state_dbg_s), int'(IDLE));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drives back-to-back beats (done on the last) and waits for result_valid; returns
  // the number of edges from the done-beat edge to result_valid.
  task automatic run_stream(input logic [15:0] d [4], input int n, output int lat);
    for (int b = 0; b < n; b++) begin
      in_valid = 1'b1;
      data_in  = d[b];
      done_in  = (b == n - 1);
      cycle();
    end
    idle_inputs();
    lat = 0;
    while (!result_valid && lat < 20) begin
      cycle();
      lat++;
    end
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    cycle();
    result_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [15:0] seq [4];

    tbl[0] = '{beats: '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000}, n: 1, exp10: 16, exp5: 16, ovf5: 0};
    tbl[1] = '{beats: '{16'h000F, 16'h00FF, 16'h0000, 16'hFFFF}, n: 4, exp10: 28, exp5: 28, ovf5: 0};
    tbl[2] = '{beats: '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000}, n: 2, exp10: 32, exp5: 31, ovf5: 1};
    tbl[3] = '{beats: '{16'h0001, 16'h0000, 16'h0000, 16'h0000}, n: 1, exp10: 1,  exp5: 1,  ovf5: 0};
    tbl[4] = '{beats: '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h0000}, n: 2, exp10: 31, exp5: 31, ovf5: 0};
    tbl[5] = '{beats: '{16'h0003, 16'h0000, 16'h0000, 16'h0000}, n: 1, exp10: 2,  exp5: 2,  ovf5: 0};

    idle_inputs();
    result_ready = 1'b0;
    model_reset();
    do_reset();
    cycle();

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      run_stream(tbl[i].beats, tbl[i].n, lat);
      chk("tbl_latency", lat, 2);
      chk("tbl_result", int'(result), tbl[i].exp10);
      chk("tbl_overflow", int'(overflow), 0);
      chk("tbl_result_w5", int'(result_s), tbl[i].exp5);
      chk("tbl_overflow_w5", int'(overflow_s), tbl[i].ovf5);
      take_result();
      chk("tbl_rv_fall", int'(result_valid), 0);
      chk("tbl_in_ready_rise", int'(in_ready), 1);
    end

    // Backpressure: result held for 10 cycles while ignored beats arrive
    seq = '{16'h00F0, 16'h0000, 16'h0000, 16'h0000};
    run_stream(seq, 1, lat);
    chk("bp_latency", lat, 2);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      data_in  = 16'($urandom);
      done_in  = 1'($urandom_range(0, 1));
      cycle();
      chk("bp_result_stable", int'(result), 4);
      chk("bp_in_ready_low", int'(in_ready), 0);
    end
    idle_inputs();
    take_result();
    chk("bp_rv_fall", int'(result_valid), 0);
    chk("bp_in_ready", int'(in_ready), 1);

    // Gaps with done_in asserted on invalid cycles
    in_valid = 1'b1; data_in = 16'h0101; done_in = 1'b0; cycle();
    in_valid = 1'b0; data_in = 16'hFFFF; done_in = 1'b1; cycle();
    cycle();
    chk("gap_no_capture", int'(result_valid), 0);
    in_valid = 1'b1; data_in = 16'h0F00; done_in = 1'b0; cycle();
    in_valid = 1'b0; data_in = 16'hFFFF; done_in = 1'b1; cycle();
    cycle();
    cycle();
    chk("gap_no_capture2", int'(result_valid), 0);
    in_valid = 1'b1; data_in = 16'h8000; done_in = 1'b1; cycle();
    idle_inputs();
    cycle();
    cycle();
    chk("gap_rv", int'(result_valid), 1);
    chk("gap_result", int'(result), 7);
    take_result();

    // Reset in the middle of a stream
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1; data_in = 16'hFFFF; done_in = 1'b0; cycle();
    end
    idle_inputs();
    do_reset();
    seq = '{16'h0003, 16'h0000, 16'h0000, 16'h0000};
    run_stream(seq, 1, lat);
    chk("rst_stream_latency", lat, 2);
    chk("rst_stream_result", int'(result), 2);
    chk("rst_stream_overflow", int'(overflow), 0);
    take_result();

    // Reset while holding a result
    seq = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    run_stream(seq, 2, lat);
    do_reset();

    // Randomized streams with gaps, ignored done_in and random consumer stalls
    for (int s = 0; s < 40; s++) begin
      int len;
      int k;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        k = 0;
        do begin
          in_valid = ($urandom_range(0, 3) != 0);
          data_in  = 16'($urandom);
          done_in  = in_valid ? (b == len - 1) : 1'($urandom_range(0, 1));
          cycle();
          k++;
        end while (!(in_valid == 1'b1) && k < 50);
      end
      k = 0;
      while (!result_valid && k < 20) begin
        in_valid = 1'($urandom_range(0, 1));
        data_in  = 16'($urandom);
        done_in  = 1'($urandom_range(0, 1));
        cycle();
        k++;
      end
      chk("rand_result_wait", int'(result_valid), 1);
      k = 0;
      while (result_valid && k < 100) begin
        result_ready = 1'($urandom_range(0, 1));
        in_valid     = 1'($urandom_range(0, 1));
        data_in      = 16'($urandom);
        done_in      = 1'($urandom_range(0, 1));
        cycle();
        k++;
      end
      chk("rand_handshake_done", int'(result_valid), 0);
      result_ready = 1'b0;
      idle_inputs();
    end

    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stoch_acc_capture.md
# stoch_acc_capture

Downstream stage for the deterministic stochastic-computing multipliers. It takes the per-cycle product lanes (`bs_data_out`) and the stream-end flag (`done`) from the multiplier. It accumulates the lanes into a binary result through a two-stage popcount/accumulate pipeline, then holds the finished count with a valid/ready handshake. It replaces the free-running `par_acc_*lanes` counter wherever a consumer needs a clean per-operation result with overflow status.

## Interface
Parameters:
- `LANES`, default 16: number of product lanes per cycle. Legal values are 8, 16 and 32.
- `WIDTH`, default 10: accumulator and result width in bits.

Ports:
- `clk`, input, 1: single clock. Everything is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `data_in`, input, LANES: product lanes for the current beat.
- `in_valid`, input, 1: `data_in` and `done_in` are valid this cycle.
- `done_in`, input, 1: marks the current valid beat as the last beat of the stream.
- `in_ready`, output, 1: the block accepts a beat this cycle.
- `result`, output, WIDTH: captured count of ones, saturated.
- `result_valid`, output, 1: `result` and `overflow` are valid.
- `result_ready`, input, 1: the consumer takes the result.
- `overflow`, output, 1: the captured stream saturated the accumulator.
- `busy`, output, 1: the state is not IDLE.

## Operation
- A beat is accepted when `in_valid` and `in_ready` are both high. `done_in` is sampled only on accepted beats and is ignored otherwise.
- State machine states:
  - IDLE: `in_ready` = 1. An accepted beat moves to ACCUM. If that beat has `done_in`, it moves to DRAIN instead, which makes a single-beat stream.
  - ACCUM: `in_ready` = 1. An accepted beat with `done_in` moves to DRAIN.
  - DRAIN: `in_ready` = 0. Lasts 2 cycles, counted by a 1-bit drain counter. It then moves to HOLD and loads `result` and `overflow`.
  - HOLD: `in_ready` = 0 and `result_valid` = 1. When `result_valid` and `result_ready` are both high, it moves to IDLE.
- Pipeline stage 1: on each accepted beat, the popcount of `data_in` is registered into `pc_reg`, which is $clog2(LANES+1) bits wide. `pc_reg` is cleared on cycles with no accepted beat.
- Pipeline stage 2: `acc <= sat(acc + pc_reg)`. Zero extension is to WIDTH+1 bits.
  - If the sum exceeds 2^WIDTH−1, `acc` is set to all-ones and the sticky `ovf_acc` is set.
- Capture: on the DRAIN→HOLD edge, `result <= acc` and `overflow <= ovf_acc`. On the same edge `acc` and `ovf_acc` clear to 0, so the next stream starts clean.
- Data on the `done_in` beat is included in the count.
- The block does not check or count stream length. Upstream bounds it with `sng_ov`.

## Timing
- Reset values:
  - `result` = 0, `result_valid` = 0, `overflow` = 0, `busy` = 0.
  - `in_ready` = 1, since the block resets to IDLE.
  - `acc`, `pc_reg` and `ovf_acc` = 0.
- Latency: call the edge that accepts the `done_in` beat edge E.
  - `acc` is final after E+1.
  - `result_valid` is high after E+2 and stays high until the handshake.
- Throughput: one beat per cycle while in ACCUM. Between streams there are at least 3 cycles plus the handshake wait with `in_ready` = 0.
- `result_valid` falls on the edge where `result_ready` is high. `in_ready` rises after that same edge. It is not combinationally tied to `result_ready`.
- `result` and `overflow` stay stable throughout HOLD.
- Saturation at exactly 2^WIDTH−1: no overflow is flagged. Only a strict exceed sets `ovf_acc`.
- Reset mid-stream, in DRAIN or in HOLD: all state is discarded immediately and the outputs return to their reset values.

## Structure
- Shared package `stoch_acc_pkg` holds:
  - the state enum `acc_state_t` with values IDLE, ACCUM, DRAIN, HOLD;
  - the function `pc_width(lanes)` = $clog2(lanes+1).
- One sub-module, `popcount_lanes #(LANES)`: a combinational adder tree that outputs `pc_width(LANES)` bits.
- Stage registers, the accumulator and the FSM live in the top module.

## Test plan
- Single-beat stream, LANES=16, `data_in` = 16'hFFFF with `done_in`: `result` = 16 and `result_valid` rises 2 edges after acceptance; `overflow` = 0.
- Four beats 16'h000F, 16'h00FF, 16'h0000, 16'hFFFF, with `done_in` on the last: `result` = 28.
- Saturation, WIDTH=5: two beats of 16'hFFFF: `result` = 31 and `overflow` = 1. A following stream of 16'h0001 alone gives `result` = 1 and `overflow` = 0.
- Backpressure: hold `result_ready` = 0 for 10 cycles. `result` stays stable, `in_ready` = 0 and `in_valid` beats are ignored. Raise `result_ready`: `result_valid` falls and `in_ready` is 1 on the next cycle.
- `in_valid` gaps and `done_in` asserted while `in_valid` = 0: there are no extra counts and no early capture. The final result equals the sum of ones over accepted beats only.
- Assert `rst` in ACCUM after 3 beats: all outputs return to their reset values. A new 1-beat stream of 16'h0003 gives `result` = 2.
